// File: rtl/hood_pkg.sv
// Shared definitions for the cooker-hood mode controller: state encoding,
// default timing constants and the per-state fan drive.
package hood_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_MENU  = 3'd1,
    ST_L1    = 3'd2,
    ST_L2    = 3'd3,
    ST_L3    = 3'd4,
    ST_COOL  = 3'd5,
    ST_CLEAN = 3'd6
  } hood_state_e;

  localparam int unsigned DEF_TICKS_PER_SEC = 100000000;
  localparam int unsigned DEF_STORM_SEC     = 60;
  localparam int unsigned DEF_COOL_SEC      = 60;
  localparam int unsigned DEF_CLEAN_SEC     = 180;

  function automatic logic [1:0] fan_for(hood_state_e s);
    logic [1:0] f;
    f = 2'd0;
    case (s)
      ST_L1, ST_COOL: f = 2'd1;
      ST_L2:          f = 2'd2;
      ST_L3:          f = 2'd3;
      default:        f = 2'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Tick divider feeding a loadable seconds down-counter; expire flags the
// cycle on which the count is about to step from 1 to 0.
module sec_countdown
  import hood_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] remaining,
  output logic       expire
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    rem_q, rem_d;
  logic          sec_end;

  assign sec_end = (tick_q == TICK_MAX);

  // The divider only runs while there is time left, so an idle counter sits at 0.
  always_comb begin
    tick_d = tick_q;
    rem_d  = rem_q;
    if (load) begin
      tick_d = '0;
      rem_d  = load_val;
    end else if (rem_q != 8'd0) begin
      if (sec_end) begin
        tick_d = '0;
        rem_d  = rem_q - 8'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      rem_q  <= 8'd0;
    end else begin
      tick_q <= tick_d;
      rem_q  <= rem_d;
    end
  end

  assign remaining = rem_q;
  assign expire    = (rem_q == 8'd1) && sec_end;

endmodule

// File: rtl/hood_mode_controller.sv
// Cooker-hood mode controller: key edge detection, mode FSM and registered
// outputs. The timed modes (L3, COOL, CLEAN) share one seconds counter.
module hood_mode_controller
  import hood_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int unsigned STORM_SEC     = DEF_STORM_SEC,
  parameter int unsigned COOL_SEC      = DEF_COOL_SEC,
  parameter int unsigned CLEAN_SEC     = DEF_CLEAN_SEC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       key_l1,
  input  logic       key_l2,
  input  logic       key_l3,
  input  logic       key_clean,
  input  logic       key_back,
  output logic [1:0] fan_level,
  output logic       clean_active,
  output logic [2:0] mode,
  output logic [7:0] remaining_sec,
  output logic       storm_used
);

  localparam logic [7:0] STORM_LD = 8'(STORM_SEC);
  localparam logic [7:0] COOL_LD  = 8'(COOL_SEC);
  localparam logic [7:0] CLEAN_LD = 8'(CLEAN_SEC);

  hood_state_e state_q, state_d;
  logic [4:0]  keys, key_q, ev;
  logic        ev_l1, ev_l2, ev_l3, ev_clean, ev_back;
  logic        storm_q, storm_d;
  logic [1:0]  fan_q;
  logic        clean_q;
  logic        cnt_load;
  logic [7:0]  cnt_val, cnt_rem;
  logic        cnt_expire;

  assign keys = {key_l1, key_l2, key_l3, key_clean, key_back};
  assign ev   = keys & ~key_q;
  assign {ev_l1, ev_l2, ev_l3, ev_clean, ev_back} = ev;

  sec_countdown #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .remaining(cnt_rem),
    .expire   (cnt_expire)
  );

  // Power loss overrides everything; loading 0 clears the remaining time.
  always_comb begin
    state_d  = state_q;
    storm_d  = storm_q;
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    if (!power_on) begin
      state_d  = ST_OFF;
      storm_d  = 1'b0;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_MENU;
        ST_MENU: begin
          if (ev_l3 && !storm_q) begin
            state_d  = ST_L3;
            storm_d  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = STORM_LD;
          end else if (ev_l2) begin
            state_d = ST_L2;
          end else if (ev_l1) begin
            state_d = ST_L1;
          end else if (ev_clean) begin
            state_d  = ST_CLEAN;
            cnt_load = 1'b1;
            cnt_val  = CLEAN_LD;
          end
        end
        ST_L1, ST_L2: begin
          if (ev_back)    state_d = ST_MENU;
          else if (ev_l2) state_d = ST_L2;
          else if (ev_l1) state_d = ST_L1;
        end
        ST_L3: begin
          if (ev_back) begin
            state_d  = ST_COOL;
            cnt_load = 1'b1;
            cnt_val  = COOL_LD;
          end else if (cnt_expire) begin
            state_d = ST_L2;
          end
        end
        ST_COOL, ST_CLEAN: begin
          if (cnt_expire) state_d = ST_MENU;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Key history resets high so keys held through reset raise no event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      storm_q <= 1'b0;
      fan_q   <= 2'd0;
      clean_q <= 1'b0;
      key_q   <= '1;
    end else begin
      state_q <= state_d;
      storm_q <= storm_d;
      fan_q   <= fan_for(state_d);
      clean_q <= (state_d == ST_CLEAN);
      key_q   <= keys;
    end
  end

  assign mode          = state_q;
  assign fan_level     = fan_q;
  assign clean_active  = clean_q;
  assign storm_used    = storm_q;
  assign remaining_sec = cnt_rem;

endmodule

// File: tb/tb_hood_mode_controller.sv
// Scenario bench for hood_mode_controller with short timing parameters;
// expected outputs are queued per cycle and compared after each clock edge.
module tb_hood_mode_controller;
  import hood_pkg::*;

  localparam logic [4:0] K_L1 = 5'b10000;
  localparam logic [4:0] K_L2 = 5'b01000;
  localparam logic [4:0] K_L3 = 5'b00100;
  localparam logic [4:0] K_CL = 5'b00010;
  localparam logic [4:0] K_BK = 5'b00001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       power_on = 1'b0;
  logic       key_l1 = 1'b0, key_l2 = 1'b0, key_l3 = 1'b0, key_clean = 1'b0, key_back = 1'b0;
  logic [1:0] fan_level;
  logic       clean_active;
  logic [2:0] mode;
  logic [7:0] remaining_sec;
  logic       storm_used;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] fan;
    logic       clean;
    logic [7:0] rem;
    logic       storm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hood_mode_controller #(
    .TICKS_PER_SEC(4),
    .STORM_SEC    (3),
    .COOL_SEC     (2),
    .CLEAN_SEC    (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .power_on     (power_on),
    .key_l1       (key_l1),
    .key_l2       (key_l2),
    .key_l3       (key_l3),
    .key_clean    (key_clean),
    .key_back     (key_back),
    .fan_level    (fan_level),
    .clean_active (clean_active),
    .mode         (mode),
    .remaining_sec(remaining_sec),
    .storm_used   (storm_used)
  );

  function automatic exp_t mk(hood_state_e s, int f, bit c, int r, bit st);
    exp_t v;
    v.mode  = s;
    v.fan   = 2'(f);
    v.clean = c;
    v.rem   = 8'(r);
    v.storm = st;
    return v;
  endfunction

  function automatic exp_t obs();
    return {mode, fan_level, clean_active, remaining_sec, storm_used};
  endfunction

  function automatic string fmt(exp_t v);
    return $sformatf("mode=%0d fan=%0d clean=%0b rem=%0d storm=%0b",
                     v.mode, v.fan, v.clean, v.rem, v.storm);
  endfunction

  task automatic set_keys(input logic [4:0] k);
    {key_l1, key_l2, key_l3, key_clean, key_back} = k;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      reset    = (i < 2);
      power_on = 1'b1;
      set_keys(i < 4 ? 5'b11111 : 5'b00000);
      sb.push_back(i < 2 ? mk(ST_OFF, 0, 0, 0, 0) : mk(ST_MENU, 0, 0, 0, 0));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset[%0d] got %s want %s", i, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_l2_select();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      power_on = (i != 0);
      set_keys((i == 2 || i == 3) ? K_L2 : 5'b0);
      case (i)
        0:       sb.push_back(mk(ST_OFF, 0, 0, 0, 0));
        1:       sb.push_back(mk(ST_MENU, 0, 0, 0, 0));
        default: sb.push_back(mk(ST_L2, 2, 0, 0, 0));
      endcase
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL l2_select[%0d] got %s want %s", i, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_storm();
    exp_t e;
    // back to MENU, then hold key_l3 for 20 cycles
    for (int k = -1; k <= 21; k++) begin
      set_keys(k == -1 ? K_BK : (k >= 1 && k <= 20) ? K_L3 : 5'b0);
      if (k <= 0)       sb.push_back(mk(ST_MENU, 0, 0, 0, 0));
      else if (k <= 12) sb.push_back(mk(ST_L3, 3, 0, 3 - (k - 1) / 4, 1));
      else              sb.push_back(mk(ST_L2, 2, 0, 0, 1));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL storm[%0d] got %s want %s", k, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_storm_used();
    exp_t e;
    logic [4:0] kt [6];
    kt = '{K_BK, 5'b0, K_L3, 5'b0, K_L1 | K_L3, 5'b0};
    for (int i = 0; i < 6; i++) begin
      set_keys(kt[i]);
      sb.push_back(i < 4 ? mk(ST_MENU, 0, 0, 0, 1) : mk(ST_L1, 1, 0, 0, 1));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL storm_used[%0d] got %s want %s", i, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_cool();
    exp_t e;
    // i: 0 power off, 1 power on, 2 key_l3, 3..7 idle, 8.. COOL phase (j = i-7)
    for (int i = 0; i < 17; i++) begin
      int j;
      j = i - 7;
      power_on = (i != 0);
      if (i == 2)      set_keys(K_L3);
      else if (j == 1) set_keys(K_BK);
      else if (j == 3) set_keys(K_L1 | K_CL | K_L3);
      else             set_keys(5'b0);
      if (i == 0)      sb.push_back(mk(ST_OFF, 0, 0, 0, 0));
      else if (i == 1) sb.push_back(mk(ST_MENU, 0, 0, 0, 0));
      else if (j < 1)  sb.push_back(mk(ST_L3, 3, 0, 3 - (i - 2) / 4, 1));
      else if (j <= 8) sb.push_back(mk(ST_COOL, 1, 0, 2 - (j - 1) / 4, 1));
      else             sb.push_back(mk(ST_MENU, 0, 0, 0, 1));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL cool[%0d] got %s want %s", i, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_clean();
    exp_t e;
    for (int k = 1; k <= 22; k++) begin
      if (k == 1)      set_keys(K_CL);
      else if (k == 3) set_keys(K_BK);
      else if (k == 5) set_keys(K_L1 | K_L2);
      else             set_keys(5'b0);
      if (k <= 20) sb.push_back(mk(ST_CLEAN, 0, 1, 5 - (k - 1) / 4, 1));
      else         sb.push_back(mk(ST_MENU, 0, 0, 0, 1));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL clean[%0d] got %s want %s", k, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_power_off_clean();
    exp_t e;
    for (int k = 1; k <= 4; k++) begin
      power_on = (k != 3);
      set_keys(k == 1 ? K_CL : 5'b0);
      if (k <= 2)      sb.push_back(mk(ST_CLEAN, 0, 1, 5, 1));
      else if (k == 3) sb.push_back(mk(ST_OFF, 0, 0, 0, 0));
      else             sb.push_back(mk(ST_MENU, 0, 0, 0, 0));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL power_off_clean[%0d] got %s want %s", k, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_reset_l3();
    exp_t e;
    for (int k = 1; k <= 4; k++) begin
      reset    = (k == 3);
      power_on = 1'b1;
      set_keys(k == 1 ? K_L3 : 5'b0);
      if (k <= 2)      sb.push_back(mk(ST_L3, 3, 0, 3, 1));
      else if (k == 3) sb.push_back(mk(ST_OFF, 0, 0, 0, 0));
      else             sb.push_back(mk(ST_MENU, 0, 0, 0, 0));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset_l3[%0d] got %s want %s", k, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0]  kt [10];
    hood_state_e st [10];
    int          ft [10];
    kt = '{K_L1, K_L2, K_L1, K_L2 | K_CL, K_BK, K_L1 | K_CL, K_BK, K_L1 | K_L2 | K_CL, K_BK, 5'b0};
    st = '{ST_L1, ST_L2, ST_L1, ST_L2, ST_MENU, ST_L1, ST_MENU, ST_L2, ST_MENU, ST_MENU};
    ft = '{1, 2, 1, 2, 0, 1, 0, 2, 0, 0};
    for (int i = 0; i < 10; i++) begin
      set_keys(kt[i]);
      sb.push_back(mk(st[i], ft[i], 0, 0, 0));
      cycle();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] got %s want %s", i, fmt(obs()), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_l2_select();
    test_storm();
    test_storm_used();
    test_cool();
    test_clean();
    test_power_off_clean();
    test_reset_l3();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hood_mode_controller.md
HOOD_MODE_CONTROLLER -- requirements
Module: hood_mode_controller

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, meaning clk cycles per second.
REQ-002 SHALL have parameter STORM_SEC, default 60, meaning the level-3 time limit in seconds.
REQ-003 SHALL have parameter COOL_SEC, default 60, meaning the post-storm extraction time in seconds.
REQ-004 SHALL have parameter CLEAN_SEC, default 180, meaning the self-clean duration in seconds.
REQ-005 SHALL have port clk, input, 1, the single system clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port power_on, input, 1, the hood power level from the power controller.
REQ-008 SHALL have ports key_l1, key_l2, key_l3, key_clean and key_back, input, 1 each, debounced level keys.
REQ-009 SHALL have port fan_level, output, 2, fan drive: 0 off, 1, 2 or 3.
REQ-010 SHALL have port clean_active, output, 1, high while self-clean runs.
REQ-011 SHALL have port mode, output, 3, the current state encoding.
REQ-012 SHALL have port remaining_sec, output, 8, seconds left in a timed state, otherwise 0.
REQ-013 SHALL have port storm_used, output, 1, high once level 3 has been used in this power cycle.

Function
REQ-014 SHALL convert each key to a one-cycle event on its rising edge; a held key SHALL give exactly one event.
REQ-015 SHALL implement the states OFF, MENU, L1, L2, L3, COOL and CLEAN; fan_level SHALL be 0, 0, 1, 2, 3, 1 and 0 respectively.
REQ-016 SHALL move from any state to OFF on the cycle after power_on=0; that transition SHALL clear storm_used and remaining_sec.
REQ-017 SHALL move from OFF to MENU on the cycle after power_on=1.
REQ-018 In MENU, simultaneous events SHALL have priority l3 > l2 > l1 > clean.
REQ-019 In MENU, l3 SHALL enter L3 only if storm_used=0; otherwise l3 SHALL be ignored and the next-priority event, if any, acted on.
REQ-020 In L1 or L2, key_l1 SHALL select L1, key_l2 SHALL select L2 and key_back SHALL select MENU; key_l3 and key_clean SHALL be ignored.
REQ-021 On L3 entry, storm_used SHALL set and remaining_sec SHALL load STORM_SEC.
REQ-022 In L3, a back event SHALL go to COOL and load COOL_SEC; reaching 0 SHALL go to L2; all other keys SHALL be ignored.
REQ-023 COOL SHALL ignore all keys and go to MENU when remaining_sec reaches 0.
REQ-024 CLEAN SHALL set clean_active=1, load CLEAN_SEC, ignore all keys and go to MENU at 0.
REQ-025 Each timed-state entry SHALL zero the tick counter.
REQ-026 remaining_sec SHALL decrement when the tick counter equals TICKS_PER_SEC-1; the tick counter SHALL then wrap to 0.
REQ-027 The exit transition SHALL occur on the same cycle that remaining_sec changes from 1 to 0.
REQ-028 remaining_sec SHALL be 0 in OFF, MENU, L1 and L2.
REQ-029 All outputs SHALL be registered, with state-change latency of 1 cycle from the event.

Reset
REQ-030 Reset SHALL put the block in OFF and set fan_level=0, clean_active=0, mode=OFF, remaining_sec=0 and storm_used=0.
REQ-031 Reset SHALL clear the tick counter and SHALL set the key-history registers to 1, so keys held through reset produce no event.
REQ-032 Reset asserted mid-state, including during L3 or CLEAN, SHALL abort immediately to the reset values.

Structure
REQ-033 The state encoding and the default second constants SHALL reside in shared package hood_pkg.
REQ-034 The tick divider and loadable seconds down-counter SHALL be sub-module sec_countdown (inputs load, load_val; outputs remaining, expire).

Verification (TICKS_PER_SEC=4, STORM_SEC=3, COOL_SEC=2, CLEAN_SEC=5)
REQ-035 power_on=1 then key_l2 -> MENU then L2, fan_level=2, remaining_sec=0.
REQ-036 From MENU, key_l3 held for 20 cycles -> a single L3 entry, storm_used=1, remaining_sec 3,2,1; 12 cycles after entry the block is in L2 with fan_level=2.
REQ-037 From L2, key_back; then in MENU, key_l3 -> stays in MENU; then key_l1 and key_l3 together -> L1.
REQ-038 Power cycle, then key_l3, then key_back after 5 cycles -> COOL, fan_level=1, remaining_sec=2; 8 cycles later the block is in MENU.
REQ-039 key_clean -> CLEAN, clean_active=1, key_back ignored; after 20 cycles MENU, clean_active=0.
REQ-040 power_on=0 during CLEAN -> OFF the next cycle with all outputs 0; reset during L3 -> reset values on the next cycle.
